// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, BCD field limits and entry validation for the clock front end.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        SET_TIME  = 2'd1,
        SET_ALARM = 2'd2
    } mode_e;

    localparam logic [7:0] HOUR_MIN = 8'h01;
    localparam logic [7:0] HOUR_MAX = 8'h12;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    localparam logic HOUR_FIELD = 1'b0;
    localparam logic MIN_FIELD  = 1'b1;

    // Hours are 01..12 with a decimal ones digit; minutes are 00..59.
    function automatic logic bcd_valid(input logic [7:0] v, input logic field);
        bcd_valid = (v[3:0] <= 4'd9) &&
                    ((field == MIN_FIELD) ? (v[7:4] <= MIN_MAX[7:4])
                                          : (v >= HOUR_MIN && v <= HOUR_MAX));
    endfunction

endpackage

// File: rtl/set_controller_key_debounce.sv
// key_debounce: synchronizes an active-low raw key, filters bounce and emits a one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_i,
    output logic level_o,
    output logic press_o
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q, level_q, prev_q, press_q;
    logic          level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level disagrees with the accepted one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (s2_q != level_q) begin
            cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            level_d = (cnt_q == CNT_LAST) ? s2_q : level_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= key_i;
            s2_q    <= s1_q;
            level_q <= level_d;
            prev_q  <= level_q;
            press_q <= prev_q & ~level_q;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/set_controller.sv
// set_controller: debounced keys drive the RUN/SET_TIME/SET_ALARM machine, field select,
// BCD validation and a one-cycle active-low write strobe towards the clock.
module set_controller
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TIMEOUT_CYCLES  = 500_000_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY_MODE,
    input  logic       KEY_FIELD,
    input  logic       KEY_SET,
    input  logic [7:0] SW_RAW,
    output logic       TS_STATE,
    output logic       AS_STATE,
    output logic       SWITCH,
    output logic       SET,
    output logic [7:0] SW_OUT,
    output logic       ERR
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [2:0] levels_unused;
    logic       mode_p, field_p, set_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .CLK(CLK), .RST(RST), .key_i(KEY_MODE), .level_o(levels_unused[0]), .press_o(mode_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_field (
        .CLK(CLK), .RST(RST), .key_i(KEY_FIELD), .level_o(levels_unused[1]), .press_o(field_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
        .CLK(CLK), .RST(RST), .key_i(KEY_SET), .level_o(levels_unused[2]), .press_o(set_p)
    );

    mode_e         state_q, state_d;
    logic          switch_q, switch_d;
    logic          err_q, err_d;
    logic          set_n_q, set_n_d;
    logic [7:0]    sw_out_q, sw_out_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          ts_q, as_q;
    logic          in_set;

    assign in_set = (state_q != RUN);

    // Priority: mode over set over field; timeout only when no key event is present.
    always_comb begin
        state_d  = state_q;
        switch_d = switch_q;
        err_d    = err_q;
        sw_out_d = sw_out_q;
        set_n_d  = 1'b1;
        if (mode_p) begin
            state_d  = (state_q == RUN) ? SET_TIME : (state_q == SET_TIME) ? SET_ALARM : RUN;
            switch_d = HOUR_FIELD;
            err_d    = 1'b0;
        end else if (in_set && set_p) begin
            sw_out_d = bcd_valid(SW_RAW, switch_q) ? SW_RAW : sw_out_q;
            set_n_d  = ~bcd_valid(SW_RAW, switch_q);
            err_d    = ~bcd_valid(SW_RAW, switch_q);
        end else if (in_set && field_p) begin
            switch_d = ~switch_q;
        end else if (in_set && idle_q == IDLE_LAST) begin
            state_d  = RUN;
            switch_d = HOUR_FIELD;
            err_d    = 1'b0;
        end
        idle_d = (mode_p || field_p || set_p || state_d == RUN) ? '0 :
                 (idle_q == IDLE_LAST) ? idle_q : idle_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            switch_q <= HOUR_FIELD;
            err_q    <= 1'b0;
            set_n_q  <= 1'b1;
            sw_out_q <= 8'h00;
            idle_q   <= '0;
            ts_q     <= 1'b0;
            as_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            switch_q <= switch_d;
            err_q    <= err_d;
            set_n_q  <= set_n_d;
            sw_out_q <= sw_out_d;
            idle_q   <= idle_d;
            ts_q     <= (state_d == SET_TIME);
            as_q     <= (state_d == SET_ALARM);
        end
    end

    assign TS_STATE = ts_q;
    assign AS_STATE = as_q;
    assign SWITCH   = switch_q;
    assign SET      = set_n_q;
    assign SW_OUT   = sw_out_q;
    assign ERR      = err_q;

endmodule

// File: tb/tb_set_controller.sv
// tb_set_controller: table-driven set/validate vectors plus hand sequences for debounce,
// timeout, simultaneous presses and reset during the strobe; strobes checked against a scoreboard.
module tb_set_controller;

    logic       CLK = 1'b0;
    logic       RST, KEY_MODE, KEY_FIELD, KEY_SET;
    logic [7:0] SW_RAW;
    logic       TS_STATE, AS_STATE, SWITCH, SET, ERR;
    logic [7:0] SW_OUT;

    set_controller #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
        .CLK(CLK), .RST(RST), .KEY_MODE(KEY_MODE), .KEY_FIELD(KEY_FIELD), .KEY_SET(KEY_SET),
        .SW_RAW(SW_RAW), .TS_STATE(TS_STATE), .AS_STATE(AS_STATE), .SWITCH(SWITCH),
        .SET(SET), .SW_OUT(SW_OUT), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [7:0] sw; logic ts; logic as_; } sb_t;
    typedef struct { logic fld; logic [7:0] raw; logic ok; } vec_t;

    sb_t  sb_q[$];
    sb_t  e;
    vec_t vecs[12];
    int   total = 0, passed = 0, strobes = 0, exp_strobes = 0, s0, n;
    logic prev_low = 1'b0;
    logic exp_switch;
    logic [7:0] exp_sw_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic press(input logic m, input logic f, input logic s);
        @(negedge CLK);
        if (m) KEY_MODE = 1'b0;
        if (f) KEY_FIELD = 1'b0;
        if (s) KEY_SET = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        KEY_MODE = 1'b1; KEY_FIELD = 1'b1; KEY_SET = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
    endtask

    // Every low SET cycle must match the oldest queued expectation and last one cycle.
    always @(negedge CLK) begin
        if (SET === 1'b0) begin
            strobes++;
            check("set_one_cycle", {31'd0, prev_low}, 32'd0);
            check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("strobe_sw_out", {24'd0, SW_OUT}, {24'd0, e.sw});
                check("strobe_ts", {31'd0, TS_STATE}, {31'd0, e.ts});
                check("strobe_as", {31'd0, AS_STATE}, {31'd0, e.as_});
                check("strobe_err", {31'd0, ERR}, 32'd0);
            end
        end
        prev_low = (SET === 1'b0);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h60, 1'b0};
        vecs[1]  = '{1'b1, 8'h45, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h13, 1'b0};
        vecs[4]  = '{1'b0, 8'h0A, 1'b0};
        vecs[5]  = '{1'b0, 8'h12, 1'b1};
        vecs[6]  = '{1'b0, 8'h20, 1'b0};
        vecs[7]  = '{1'b1, 8'h5A, 1'b0};
        vecs[8]  = '{1'b1, 8'h00, 1'b1};
        vecs[9]  = '{1'b1, 8'h59, 1'b1};
        vecs[10] = '{1'b0, 8'h01, 1'b1};
        vecs[11] = '{1'b0, 8'h09, 1'b1};

        RST = 1'b1; KEY_MODE = 1'b1; KEY_FIELD = 1'b1; KEY_SET = 1'b1; SW_RAW = 8'h00;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_ts", {31'd0, TS_STATE}, 32'd0);
        check("rst_as", {31'd0, AS_STATE}, 32'd0);
        check("rst_switch", {31'd0, SWITCH}, 32'd0);
        check("rst_set", {31'd0, SET}, 32'd1);
        check("rst_sw_out", {24'd0, SW_OUT}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        RST = 1'b0;
        repeat (2) @(posedge CLK);

        // Bounce shorter than the debounce window, then a clean hold.
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            KEY_MODE = i[0];
            @(negedge CLK);
        end
        check("bounce_no_mode", {31'd0, TS_STATE}, 32'd0);
        @(negedge CLK);
        KEY_MODE = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        check("ts_not_early", {31'd0, TS_STATE}, 32'd0);
        @(posedge CLK);
        #1;
        check("ts_latency", {31'd0, TS_STATE}, 32'd1);
        KEY_MODE = 1'b1;
        repeat (10) @(posedge CLK);
        #1;
        check("single_transition_ts", {31'd0, TS_STATE}, 32'd1);
        check("single_transition_as", {31'd0, AS_STATE}, 32'd0);

        SW_RAW = 8'h11;
        sb_q.push_back('{8'h11, 1'b1, 1'b0});
        exp_strobes++;
        s0 = strobes;
        press(1'b0, 1'b0, 1'b1);
        check("t2_sw_out", {24'd0, SW_OUT}, 32'h11);
        check("t2_err", {31'd0, ERR}, 32'd0);
        check("t2_strobes", strobes - s0, 32'd1);
        exp_sw_out = 8'h11;

        press(1'b1, 1'b0, 1'b0);
        exp_switch = 1'b0;
        check("alarm_as", {31'd0, AS_STATE}, 32'd1);
        check("alarm_ts", {31'd0, TS_STATE}, 32'd0);
        check("alarm_switch", {31'd0, SWITCH}, 32'd0);
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].fld != exp_switch) begin
                press(1'b0, 1'b1, 1'b0);
                exp_switch = ~exp_switch;
                check("vec_switch", {31'd0, SWITCH}, {31'd0, exp_switch});
            end
            SW_RAW = vecs[i].raw;
            if (vecs[i].ok) begin
                sb_q.push_back('{vecs[i].raw, 1'b0, 1'b1});
                exp_strobes++;
                exp_sw_out = vecs[i].raw;
            end
            s0 = strobes;
            press(1'b0, 1'b0, 1'b1);
            check("vec_err", {31'd0, ERR}, {31'd0, !vecs[i].ok});
            check("vec_sw_out", {24'd0, SW_OUT}, {24'd0, exp_sw_out});
            check("vec_strobes", strobes - s0, {31'd0, vecs[i].ok});
        end

        press(1'b1, 1'b0, 1'b0);
        check("run_ts", {31'd0, TS_STATE}, 32'd0);
        check("run_as", {31'd0, AS_STATE}, 32'd0);
        check("run_err_cleared", {31'd0, ERR}, 32'd0);
        check("run_switch_cleared", {31'd0, SWITCH}, 32'd0);
        press(1'b1, 1'b0, 1'b0);
        check("reenter_ts", {31'd0, TS_STATE}, 32'd1);
        s0 = strobes;
        n = 0;
        while (TS_STATE === 1'b1 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("timeout_cycles", n, 32'd54);
        check("timeout_as", {31'd0, AS_STATE}, 32'd0);
        check("timeout_no_strobe", strobes - s0, 32'd0);
        SW_RAW = 8'h23;
        press(1'b0, 1'b0, 1'b1);
        check("run_set_no_strobe", strobes - s0, 32'd0);
        check("run_set_sw_out", {24'd0, SW_OUT}, {24'd0, exp_sw_out});
        check("run_set_err", {31'd0, ERR}, 32'd0);

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("t5_switch_min", {31'd0, SWITCH}, 32'd1);
        SW_RAW = 8'h30;
        s0 = strobes;
        press(1'b1, 1'b0, 1'b1);
        check("t5_as", {31'd0, AS_STATE}, 32'd1);
        check("t5_ts", {31'd0, TS_STATE}, 32'd0);
        check("t5_switch", {31'd0, SWITCH}, 32'd0);
        check("t5_no_strobe", strobes - s0, 32'd0);
        check("t5_sw_out", {24'd0, SW_OUT}, {24'd0, exp_sw_out});

        SW_RAW = 8'h07;
        sb_q.push_back('{8'h07, 1'b0, 1'b1});
        exp_strobes++;
        @(negedge CLK);
        KEY_SET = 1'b0;
        n = 0;
        while (SET !== 1'b0 && n < 20) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("t6_strobe_seen", {31'd0, SET}, 32'd0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("t6_set", {31'd0, SET}, 32'd1);
        check("t6_ts", {31'd0, TS_STATE}, 32'd0);
        check("t6_as", {31'd0, AS_STATE}, 32'd0);
        check("t6_sw_out", {24'd0, SW_OUT}, 32'd0);
        RST = 1'b0;
        KEY_SET = 1'b1;
        repeat (20) @(posedge CLK);
        #1;
        check("t6_after_ts", {31'd0, TS_STATE}, 32'd0);
        check("strobe_count", strobes, exp_strobes);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
